// File: rtl/dr_arb_pkg.sv
// ============================================================================
//  dr_arb_pkg
//  Shared types and constants for the shared-port round-robin arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package dr_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shared_port_arbiter_if.sv
// ============================================================================
//  shared_port_arbiter_if
//  Requester, resource and status signals of the shared compute/memory port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface shared_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  import dr_arb_pkg::*;

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*WORD_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [WORD_SIZE-1:0]         rsp_data;
  logic                         rsp_err;
  logic                         res_valid;
  logic                         res_ready;
  logic [WORD_SIZE-1:0]         res_data;
  logic                         res_rsp_valid;
  logic [WORD_SIZE-1:0]         res_rsp_data;
  logic [SEL_W-1:0]             sel;
  logic                         busy;
  logic                         err_spurious;

  modport master (
    input  req, req_data, res_ready, res_rsp_valid, res_rsp_data,
    output gnt, rsp_valid, rsp_data, rsp_err, res_valid, res_data,
           sel, busy, err_spurious
  );

  modport slave (
    output req, req_data, res_ready, res_rsp_valid, res_rsp_data,
    input  gnt, rsp_valid, rsp_data, rsp_err, res_valid, res_data,
           sel, busy, err_spurious
  );

endinterface

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
//  rr_pick4
//  Combinational 4-way round-robin pick starting the search at ptr.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick4 (
  input  wire logic [3:0] req_i,
  input  wire logic [1:0] ptr_i,
  output logic      [1:0] winner_o,
  output logic            any_o
);

  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] off;

  // Rotate so bit 0 is the requester at ptr; the first set bit is the offset.
  assign dbl = {req_i, req_i} >> ptr_i;
  assign rot = dbl[3:0];

  always_comb begin
    off = 2'd0;
    if      (rot[0]) off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
  end

  assign winner_o = ptr_i + off;
  assign any_o    = |req_i;

endmodule

`default_nettype wire

// File: rtl/shared_port_arbiter.sv
// ============================================================================
//  shared_port_arbiter
//  Round-robin sequencer sharing one port among 4 requesters, one transaction
//  outstanding, with response routing and optional timeout.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module shared_port_arbiter
  import dr_arb_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int TIMEOUT   = 255
) (
  input wire logic              clk,
  input wire logic              reset_n,
  shared_port_arbiter_if.master bus
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit              TO_EN    = (TIMEOUT != 0);

  arb_state_t           state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [SEL_W-1:0]     owner_q, owner_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 err_spur_q, err_spur_d;

  logic [SEL_W-1:0]     winner;
  logic                 any;

  rr_pick4 u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_o    (any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_spur_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_spur_q  <= err_spur_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    // A response strobe is only meaningful while a transaction is outstanding.
    err_spur_d  = err_spur_q | (bus.res_rsp_valid && (state_q != WAIT_RESP));

    unique case (state_q)
      IDLE: begin
        if (any) begin
          owner_d = winner;
          data_d  = bus.req_data[winner*WORD_SIZE +: WORD_SIZE];
          gnt_d   = onehot(winner);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.res_ready) begin
          cnt_d   = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        cnt_d = cnt_q + 1'b1;
        // A response on the timeout cycle takes priority over the timeout.
        if (bus.res_rsp_valid) begin
          rsp_data_d  = bus.res_rsp_data;
          rsp_err_d   = 1'b0;
          rsp_valid_d = onehot(owner_q);
          ptr_d       = owner_q + 1'b1;
          state_d     = IDLE;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = onehot(owner_q);
          ptr_d       = owner_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt          = gnt_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.res_valid    = (state_q == ISSUE);
  assign bus.res_data     = data_q;
  assign bus.sel          = owner_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.err_spurious = err_spur_q;

endmodule

`default_nettype wire

// File: tb/tb_shared_port_arbiter.sv
// ============================================================================
//  tb_shared_port_arbiter
//  Randomized bench with a transaction-level model feeding a scoreboard.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shared_port_arbiter;
  import dr_arb_pkg::*;

  localparam int W  = 16;
  localparam int TO = 8;

  typedef struct {
    int         cyc;
    int         idx;
    logic [W-1:0] data;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  shared_port_arbiter_if #(.WORD_SIZE(W)) bus ();

  shared_port_arbiter #(.WORD_SIZE(W), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q_gnt[$];
  exp_t q_rsp[$];
  exp_t q_iss[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0]   pend;
  logic [W-1:0] rdat [4];
  int           m_ptr;
  bit           spur_set;
  int           spur_cyc;
  bit           noise_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event/none expected opposite (cycle %0d)", name, cyc);
  endtask

  // Round-robin rule: first pending requester searching from ptr upward, mod 4.
  function automatic int pick(input logic [3:0] p, input int ptr);
    for (int k = 0; k < 4; k++)
      if (p[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input logic [3:0] extra);
    bus.req = pend | extra;
    for (int i = 0; i < 4; i++) bus.req_data[i*W +: W] = rdat[i];
  endtask

  // Caller guarantees the arbiter is idle and pend != 0.
  task automatic run_txn(input int rdly, input int d, input logic [W-1:0] rd);
    int   w;
    exp_t e;
    drive_req(4'b0);
    w     = pick(pend, m_ptr);
    e.cyc = cyc + 1; e.idx = w; e.data = rdat[w]; e.err = 1'b0;
    q_gnt.push_back(e);
    e.cyc = -1;
    q_iss.push_back(e);
    step();
    pend[w] = 1'b0;
    drive_req(noise_en ? (4'($urandom) & ~pend) : 4'b0);
    repeat (rdly) begin
      bus.res_ready = 1'b0;
      step();
    end
    bus.res_ready = 1'b1;
    q_iss[q_iss.size()-1].cyc = cyc;
    step();
    bus.res_ready = 1'b0;
    if (d < TO) begin
      repeat (d) step();
      bus.res_rsp_valid = 1'b1;
      bus.res_rsp_data  = rd;
      e.data = rd; e.err = 1'b0;
    end else begin
      repeat (TO - 1) step();
      bus.res_rsp_data = rd;
      e.data = '0; e.err = 1'b1;
    end
    e.cyc = cyc + 1; e.idx = w;
    q_rsp.push_back(e);
    step();
    bus.res_rsp_valid = 1'b0;
    m_ptr = (w + 1) % 4;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},          bus.gnt,          0);
    chk({tag, "_rsp_valid"},    bus.rsp_valid,    0);
    chk({tag, "_rsp_data"},     bus.rsp_data,     0);
    chk({tag, "_rsp_err"},      bus.rsp_err,      0);
    chk({tag, "_res_valid"},    bus.res_valid,    0);
    chk({tag, "_res_data"},     bus.res_data,     0);
    chk({tag, "_sel"},          bus.sel,          0);
    chk({tag, "_busy"},         bus.busy,         0);
    chk({tag, "_err_spurious"}, bus.err_spurious, 0);
  endtask

  // Scoreboard monitor: compares whenever the DUT presents an event.
  exp_t m_e;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("err_spurious", bus.err_spurious, (spur_set && cyc >= spur_cyc) ? 1 : 0);

      if (bus.gnt != 4'b0) begin
        if (q_gnt.size() == 0) flag("gnt_unexpected");
        else begin
          m_e = q_gnt.pop_front();
          chk("gnt_cycle",   cyc,      m_e.cyc);
          chk("gnt",         bus.gnt,  onehot(2'(m_e.idx)));
          chk("sel_at_gnt",  bus.sel,  m_e.idx);
          chk("busy_at_gnt", bus.busy, 1);
        end
      end else if (q_gnt.size() > 0 && q_gnt[0].cyc <= cyc) begin
        flag("gnt_missing");
        void'(q_gnt.pop_front());
      end

      if (bus.rsp_valid != 4'b0) begin
        if (q_rsp.size() == 0) flag("rsp_unexpected");
        else begin
          m_e = q_rsp.pop_front();
          chk("rsp_cycle",   cyc,           m_e.cyc);
          chk("rsp_valid",   bus.rsp_valid, onehot(2'(m_e.idx)));
          chk("rsp_data",    bus.rsp_data,  m_e.data);
          chk("rsp_err",     bus.rsp_err,   m_e.err);
          chk("sel_at_rsp",  bus.sel,       m_e.idx);
          chk("busy_at_rsp", bus.busy,      0);
        end
      end else if (q_rsp.size() > 0 && q_rsp[0].cyc <= cyc) begin
        flag("rsp_missing");
        void'(q_rsp.pop_front());
      end

      if (bus.res_valid) begin
        if (q_iss.size() == 0) flag("issue_unexpected");
        else begin
          chk("res_data", bus.res_data, q_iss[0].data);
          if (bus.res_ready) begin
            chk("issue_cycle", cyc, q_iss[0].cyc);
            void'(q_iss.pop_front());
          end
        end
      end else if (q_iss.size() > 0 && q_iss[0].cyc >= 0 && q_iss[0].cyc <= cyc) begin
        flag("issue_missing");
        void'(q_iss.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin : driver
    int   w;
    exp_t e;
    bus.req = '0; bus.req_data = '0; bus.res_ready = 1'b0;
    bus.res_rsp_valid = 1'b0; bus.res_rsp_data = '0;
    pend = '0; m_ptr = 0; spur_set = 1'b0; spur_cyc = 0; noise_en = 1'b0;
    for (int i = 0; i < 4; i++) rdat[i] = '0;

    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    // Single requester 2
    pend = 4'b0100; rdat[2] = 16'h1234;
    run_txn(0, 3, 16'hBEEF);

    // All requesters continuously asserted
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 4; i++) if (!pend[i]) rdat[i] = W'($urandom);
      pend = 4'hF;
      run_txn(0, 0, W'($urandom));
    end

    // Issue held off for 5 cycles
    if (pend == 4'b0) begin pend[1] = 1'b1; rdat[1] = W'($urandom); end
    run_txn(5, 2, W'($urandom));

    // Timeout, response on the timeout cycle, and late timeout
    for (int t = 0; t < 3; t++) begin
      if (pend == 4'b0) begin pend[t] = 1'b1; rdat[t] = W'($urandom); end
      run_txn(t, (t == 1) ? TO - 1 : TO + t, W'($urandom));
    end

    // Randomized traffic with withdrawn noise requests while busy
    noise_en = 1'b1;
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req = 4'b0;
        step();
      end
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          rdat[i] = W'($urandom);
        end
      if (pend == 4'b0) begin
        w = $urandom_range(0, 3);
        pend[w] = 1'b1;
        rdat[w] = W'($urandom);
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, TO + 1), W'($urandom));
    end
    noise_en = 1'b0;

    // Spurious response strobe while idle
    pend = 4'b0;
    drive_req(4'b0);
    step();
    bus.res_rsp_valid = 1'b1;
    bus.res_rsp_data  = 16'hDEAD;
    spur_set = 1'b1;
    spur_cyc = cyc + 1;
    step();
    bus.res_rsp_valid = 1'b0;
    repeat (3) step();
    pend[3] = 1'b1; rdat[3] = W'($urandom);
    run_txn(0, 1, W'($urandom));

    // Reset while waiting for a response
    pend = 4'b0010; rdat[1] = W'($urandom);
    drive_req(4'b0);
    w = pick(pend, m_ptr);
    e.cyc = cyc + 1; e.idx = w; e.data = rdat[w]; e.err = 1'b0;
    q_gnt.push_back(e);
    e.cyc = -1;
    q_iss.push_back(e);
    step();
    pend[w] = 1'b0;
    drive_req(4'b0);
    bus.res_ready = 1'b1;
    q_iss[q_iss.size()-1].cyc = cyc;
    step();
    bus.res_ready = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q_gnt.delete(); q_rsp.delete(); q_iss.delete();
    spur_set = 1'b0;
    m_ptr = 0;
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // First grant after reset goes to requester 0
    for (int i = 0; i < 4; i++) rdat[i] = W'($urandom);
    pend = 4'hF;
    run_txn(0, 2, W'($urandom));
    pend = 4'b0;
    drive_req(4'b0);
    repeat (3) step();

    chk("gnt_queue_drained", q_gnt.size(), 0);
    chk("rsp_queue_drained", q_rsp.size(), 0);
    chk("iss_queue_drained", q_iss.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shared_port_arbiter.md
Name: shared_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16-bit compute/memory port among 4 requesters in the digit-recognition datapath.
- Drives the select lines of the shared 4:1 operand mux and 1:4 result demux through `sel`.
- Keeps exactly one transaction outstanding.
- Returns each response to the owning requester, or signals a timeout error.

Parameters:
- WORD_SIZE, 16, data width of request and response words.
- TIMEOUT, 255, max cycles in WAIT_RESP before forced error response; 0 disables timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  4  per-requester request; held high until the matching gnt bit is seen
- req_data  in  4*WORD_SIZE  requester i's word at [i*WORD_SIZE +: WORD_SIZE]
- gnt  out  4  one-hot, one-cycle pulse: request accepted and data captured
- rsp_valid  out  4  one-hot, one-cycle pulse: response for requester i
- rsp_data  out  WORD_SIZE  response word, broadcast, valid with rsp_valid
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout, rsp_data = 0
- res_valid  out  1  issue valid to shared resource
- res_ready  in  1  resource accepts issue
- res_data  out  WORD_SIZE  issued word
- res_rsp_valid  in  1  resource response strobe
- res_rsp_data  in  WORD_SIZE  resource response word
- sel  out  2  current owner index; drives external mux/demux select
- busy  out  1  state != IDLE
- err_spurious  out  1  sticky: res_rsp_valid seen outside WAIT_RESP

Behaviour:

Reset (async, reset_n=0):
- state=IDLE, ptr=0, owner=0, data_q=0, cnt=0.
- All outputs 0.

FSM states: IDLE, ISSUE, WAIT_RESP (registered state).

IDLE:
- If req != 0, the winner is the first set bit searching ptr, ptr+1, ... mod 4.
- At the next edge: owner<=winner, data_q<=req_data[winner], gnt<=onehot(winner) for 1 cycle, state<=ISSUE.
- If req == 0, remain in IDLE.

ISSUE:
- res_valid=1, res_data=data_q; both are stable while res_ready=0.
- On res_valid & res_ready: state<=WAIT_RESP, cnt<=0.

WAIT_RESP:
- cnt increments each cycle.
- On res_rsp_valid: rsp_data<=res_rsp_data, rsp_err<=0, rsp_valid<=onehot(owner) for 1 cycle.
- On timeout (TIMEOUT != 0 and cnt == TIMEOUT-1 with no response): rsp_data<=0, rsp_err<=1, rsp_valid<=onehot(owner) for 1 cycle.
- Either event then sets ptr<=owner+1 (mod 4) and state<=IDLE.

Outputs and timing:
- sel = owner, registered; valid from the cycle gnt pulses until leaving WAIT_RESP.
- res_valid, busy: combinational from state only.
- Minimum latency, req to gnt: 1 cycle.
- Back-to-back throughput: re-arbitration occurs in the cycle after rsp_valid.

Boundary conditions:
- Response and timeout in the same cycle: the response wins, rsp_err=0.
- res_rsp_valid in IDLE or ISSUE (including the res_ready cycle): ignored; err_spurious<=1 (sticky until reset).
- req toggled low before gnt: the request is withdrawn; no gnt.
- A req bit still high in the cycle gnt is seen is not double-granted, because the next arbitration happens only after the response.
- reset_n low mid-transaction: immediate return to reset values. No rsp_valid is produced for the aborted transaction.
- ptr wraps 3 -> 0.
- All requesters continuously requesting: grant order is 0,1,2,3,0,...

Decomposition:
- Package dr_arb_pkg contains:
  - NUM_REQ=4
  - SEL_W=2
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} arb_state_t
- Sub-module rr_pick4, combinational: inputs req[3:0] and ptr[1:0]; outputs winner[1:0] and any.

Test Plan:
- Single requester: req=4'b0100, data 16'h1234, res_ready=1, response 16'hBEEF after 3 cycles -> gnt=4'b0100 one cycle; res_data=16'h1234; sel=2; rsp_valid=4'b0100 with rsp_data=16'hBEEF, rsp_err=0.
- All four requesting continuously, instant ready/response -> grant order 0,1,2,3,0. ptr goes 1,2,3,0 after each response.
- res_ready held 0 for 5 cycles -> res_valid and res_data stay stable; no state change until ready.
- TIMEOUT=8, no response -> rsp_valid=onehot(owner) exactly 8 cycles after entering WAIT_RESP, with rsp_err=1 and rsp_data=0; the next arbitration proceeds.
- res_rsp_valid pulsed in IDLE -> err_spurious=1 and stays 1; no rsp_valid. Response arriving on the timeout cycle -> rsp_err=0.
- reset_n dropped during WAIT_RESP -> all outputs 0 immediately. After release, first grant goes to the lowest-index requester (ptr=0).
